// File: rtl/mtimer.sv
// mtimer: machine timer with a 64-bit mtime counter, a 64-bit mtimecmp
// compare register and a registered timer interrupt (o_mtip).
// Registers are reached through a single-outstanding request/response port.
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_req/i_we       request valid, 1 = write
//   i_addr           byte address within the register window
//   i_wdata/i_wstrb  write data and byte enables
//   o_ready          request can be accepted (IDLE)
//   o_rvalid         one-cycle response pulse, with o_rdata/o_err
//   o_mtip           machine timer interrupt pending (mtime >= mtimecmp)
module mtimer #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic              o_mtip
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mtip_q, mtip_d;

  logic tick;
  logic sel_lo, sel_hi, sel_cmp_lo, sel_cmp_hi, sel_snap, acc_err;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] wd,
                                        input logic [3:0]  st);
    logic [31:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Full-address compare also rejects misaligned addresses.
  always_comb begin
    sel_lo     = (i_addr == ADDR_W'(32'h00));
    sel_hi     = (i_addr == ADDR_W'(32'h04));
    sel_cmp_lo = (i_addr == ADDR_W'(32'h08));
    sel_cmp_hi = (i_addr == ADDR_W'(32'h0C));
    sel_snap   = (i_addr == ADDR_W'(32'h10));
    acc_err    = !(sel_lo || sel_hi || sel_cmp_lo || sel_cmp_hi || sel_snap)
                 || (i_we && sel_snap);
  end

  always_comb begin
    state_d    = state_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    hi_snap_d  = hi_snap_q;
    rdata_d    = '0;
    err_d      = 1'b0;
    mtip_d     = (mtime_q >= mtimecmp_q);

    tick    = (presc_q == 32'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + 32'd1;

    if (tick) mtime_d = mtime_q + 64'd1;

    // Software writes are evaluated after the tick so they override it;
    // reads sample the pre-tick register values.
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          state_d = S_RESP;
          if (acc_err) begin
            err_d = 1'b1;
          end else if (i_we) begin
            if (sel_lo)     mtime_d    = {mtime_q[63:32], merge(mtime_q[31:0], i_wdata, i_wstrb)};
            if (sel_hi)     mtime_d    = {merge(mtime_q[63:32], i_wdata, i_wstrb), mtime_q[31:0]};
            if (sel_cmp_lo) mtimecmp_d = {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], i_wdata, i_wstrb)};
            if (sel_cmp_hi) mtimecmp_d = {merge(mtimecmp_q[63:32], i_wdata, i_wstrb), mtimecmp_q[31:0]};
          end else begin
            if (sel_lo) begin
              rdata_d   = mtime_q[31:0];
              hi_snap_d = mtime_q[63:32];
            end
            if (sel_hi)     rdata_d = mtime_q[63:32];
            if (sel_cmp_lo) rdata_d = mtimecmp_q[31:0];
            if (sel_cmp_hi) rdata_d = mtimecmp_q[63:32];
            if (sel_snap)   rdata_d = hi_snap_q;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      hi_snap_q  <= '0;
      presc_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      hi_snap_q  <= hi_snap_d;
      presc_q    <= presc_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mtip_q     <= mtip_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_rvalid = (state_q == S_RESP);
  assign o_rdata  = rdata_q;
  assign o_err    = err_q;
  assign o_mtip   = mtip_q;

endmodule

// File: tb/tb_mtimer.sv
module tb_mtimer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [4:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wstrb = '0;
  logic        o_ready, o_rvalid, o_err, o_mtip;
  logic [31:0] o_rdata;

  always #5 i_clk = ~i_clk;

  mtimer #(.PRESCALE(1), .ADDR_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_err(o_err), .o_mtip(o_mtip)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] sb_q[$];

  // mtime model: value = mt_base + edges elapsed since cyc_base
  int unsigned cyc = 0;
  int unsigned cyc_base = 0;
  logic [63:0] mt_base = '0;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [63:0] mtime_now();
    return mt_base + 64'(cyc - cyc_base);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge i_clk) begin
    if (o_rvalid) begin
      logic [32:0] e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected: got rdata=%h err=%b with no expectation", o_rdata, o_err);
      end else begin
        e = sb_q.pop_front();
        if ({o_rdata, o_err} !== e) begin
          failures++;
          $display("FAIL resp: got rdata=%h err=%b expected rdata=%h err=%b",
                   o_rdata, o_err, e[32:1], e[0]);
        end
      end
    end
  end

  task automatic txn_issue(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
    chk("ready_before_req", {63'd0, o_ready}, 64'd1);
    sb_q.push_back({exp_rd, exp_err});
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wd; i_wstrb = st;
    @(posedge i_clk); #1;
    i_req = 1'b0; i_we = 1'b0; i_wstrb = '0;
  endtask

  task automatic txn_finish();
    @(posedge i_clk); #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    txn_issue(1'b0, addr, '0, '0, exp_rd, exp_err);
    txn_finish();
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] st, input logic exp_err);
    txn_issue(1'b1, addr, wd, st, '0, exp_err);
    txn_finish();
  endtask

  // Full-word mtime write; model is rebased to the committed value.
  task automatic wr_mtime(input logic [4:0] addr, input logic [31:0] wd);
    logic [63:0] nv;
    nv = mtime_now();
    if (addr == 5'h00) nv[31:0] = wd; else nv[63:32] = wd;
    txn_issue(1'b1, addr, wd, 4'hF, '0, 1'b0);
    mt_base = nv; cyc_base = cyc;
    txn_finish();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] mt;
    // Reset and reset-state checks
    @(posedge i_clk); #1 i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0; mt_base = '0; cyc_base = cyc;
    chk("rst_ready",  {63'd0, o_ready},  64'd1);
    chk("rst_rvalid", {63'd0, o_rvalid}, 64'd0);
    chk("rst_rdata",  {32'd0, o_rdata},  64'd0);
    chk("rst_err",    {63'd0, o_err},    64'd0);
    chk("rst_mtip",   {63'd0, o_mtip},   64'd0);

    // Idle 10 cycles then read mtime low: 10
    repeat (10) @(posedge i_clk); #1;
    rd(5'h00, 32'd10, 1'b0);
    chk("mtip_low", {63'd0, o_mtip}, 64'd0);

    // mtimecmp = 50, watch o_mtip rise one cycle after mtime == 50
    wr(5'h0C, 32'd0, 4'hF, 1'b0);
    wr(5'h08, 32'd50, 4'hF, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(posedge i_clk); #1;
      mt = mtime_now();
      chk("mtip_track", {63'd0, o_mtip}, {63'd0, (mt - 64'd1) >= 64'd50});
    end
    // Raise mtimecmp: o_mtip falls one cycle after the commit
    txn_issue(1'b1, 5'h0C, 32'd1, 4'hF, '0, 1'b0);
    chk("mtip_at_commit", {63'd0, o_mtip}, 64'd1);
    txn_finish();
    chk("mtip_after_raise", {63'd0, o_mtip}, 64'd0);

    // 64-bit wrap: FFFFFFFF_FFFFFFFE + 3 ticks = 1
    wr_mtime(5'h04, 32'hFFFF_FFFF);
    wr_mtime(5'h00, 32'hFFFF_FFFE);
    repeat (2) @(posedge i_clk); #1;
    rd(5'h00, 32'h0000_0001, 1'b0);
    rd(5'h04, 32'h0000_0000, 1'b0);

    // Snapshot coherency across a low-word wrap
    wr_mtime(5'h04, 32'h5);
    wr_mtime(5'h00, 32'hFFFF_FFFE);
    rd(5'h00, 32'hFFFF_FFFF, 1'b0);
    rd(5'h10, 32'h5, 1'b0);
    rd(5'h04, 32'h6, 1'b0);

    // Error accesses leave state unchanged
    rd(5'h02, 32'h0, 1'b1);
    wr(5'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd(5'h14, 32'h0, 1'b1);
    wr(5'h09, 32'h1234_5678, 4'hF, 1'b1);
    wr(5'h01, 32'h0, 4'hF, 1'b1);
    rd(5'h10, 32'h5, 1'b0);
    rd(5'h08, 32'd50, 1'b0);
    rd(5'h0C, 32'd1, 1'b0);
    mt = mtime_now();
    rd(5'h00, mt[31:0], 1'b0);

    // Byte strobes
    wr(5'h08, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(5'h08, 32'hAABB_CCDD, 4'b0010, 1'b0);
    rd(5'h08, 32'hFFFF_CCFF, 1'b0);
    wr(5'h08, 32'h0000_0000, 4'b0000, 1'b0);
    rd(5'h08, 32'hFFFF_CCFF, 1'b0);
    chk("mtip_high_before_rst", {63'd0, o_mtip}, 64'd1);

    // Reset asserted during RESP
    mt = mtime_now();
    txn_issue(1'b0, 5'h00, '0, '0, mt[31:0], 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("rstresp_rvalid", {63'd0, o_rvalid}, 64'd0);
    chk("rstresp_ready",  {63'd0, o_ready},  64'd1);
    chk("rstresp_rdata",  {32'd0, o_rdata},  64'd0);
    chk("rstresp_err",    {63'd0, o_err},    64'd0);
    chk("rstresp_mtip",   {63'd0, o_mtip},   64'd0);
    i_rst = 1'b0; mt_base = '0; cyc_base = cyc;
    mt = mtime_now();
    rd(5'h00, mt[31:0], 1'b0);
    rd(5'h08, 32'hFFFF_FFFF, 1'b0);
    rd(5'h0C, 32'hFFFF_FFFF, 1'b0);
    rd(5'h10, 32'h0, 1'b0);

    repeat (3) @(posedge i_clk); #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
